// File: rtl/mult_arbiter_pkg.sv
// Shared constants and types for the multiplier arbiter.
// State encodings, datapath widths and the operand bundle.
package mult_arbiter_pkg;

  localparam int MULT_W       = 32;
  localparam int PROD_W       = 64;
  localparam int MULT_LATENCY = 33;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef struct packed {
    logic [MULT_W-1:0] op1;
    logic [MULT_W-1:0] op2;
  } operands_t;

endpackage

// File: rtl/mult_arbiter_rr.sv
// Round-robin picker: first requester after last_i, cyclically.
// Pure combinational; any_o flags that some grant was made.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int          pos;
  logic [IW-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    j     = '0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(last_i) + k) % N;
      j   = IW'(pos);
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one iterative signed multiplier among NREQ requesters.
// One op in flight: IDLE -> ISSUE -> WAIT -> RESP, with a watchdog.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 40
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*MULT_W-1:0] req_op1,
  input  logic [NREQ*MULT_W-1:0] req_op2,
  output logic [NREQ-1:0]        resp_valid,
  input  logic [NREQ-1:0]        resp_ready,
  output logic [PROD_W-1:0]      resp_product,
  output logic                   resp_err,
  output logic                   mult_begin,
  output logic [MULT_W-1:0]      mult_op1,
  output logic [MULT_W-1:0]      mult_op2,
  input  logic [PROD_W-1:0]      product,
  input  logic                   mult_end,
  output logic                   busy
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  operands_t         op_q, op_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic              err_q, err_d;
  logic [TW-1:0]     timer_q, timer_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;
  operands_t         sel_op;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  always_comb begin
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IW'(i)) begin
        sel_op.op1 = req_op1[i*MULT_W +: MULT_W];
        sel_op.op2 = req_op2[i*MULT_W +: MULT_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    prod_d  = prod_q;
    err_d   = err_q;
    timer_d = timer_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (arb_any) begin
          state_d = S_ISSUE;
          gnt_d   = arb_idx;
          op_d    = sel_op;
        end
      end
      (state_q == S_ISSUE): begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      (state_q == S_WAIT): begin
        if (mult_end) begin
          state_d = S_RESP;
          prod_d  = product;
          err_d   = 1'b0;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          // Multiplier never finished: report an abort with a zero product
          state_d = S_RESP;
          prod_d  = '0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      (state_q == S_RESP): begin
        if (resp_ready[gnt_q]) begin
          state_d = S_IDLE;
          last_d  = gnt_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= IW'(NREQ - 1);
      gnt_q   <= '0;
      op_q    <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (!reset && state_q == S_IDLE) begin
      req_ready = arb_gnt;
    end
  end

  always_comb begin
    resp_valid = '0;
    if (!reset && state_q == S_RESP) begin
      resp_valid[gnt_q] = 1'b1;
    end
  end

  // Holding begin through reset restarts whatever the multiplier was doing
  assign mult_begin   = reset | (state_q == S_ISSUE);
  assign mult_op1     = op_q.op1;
  assign mult_op2     = op_q.op2;
  assign resp_product = prod_q;
  assign resp_err     = err_q;
  assign busy         = (state_q != S_IDLE);

endmodule
